// File: rtl/jlsemi_util_clkdiv_multi_phase_pkg.sv
// Shared constants for the multi-phase clock divider slice.
package jlsemi_util_clkdiv_multi_phase_pkg;

  localparam int unsigned CLKDIV_CNT_W = 9;
  localparam int unsigned DIV_MIN      = 2;

  // Sticky error flag encoding, set when an applied config was illegal.
  typedef enum logic {
    CFG_OK  = 1'b0,
    CFG_ERR = 1'b1
  } cfg_err_e;

endpackage

// File: rtl/jlsemi_util_async_reset_low_sync.sv
// Active-low reset synchroniser: asynchronous assert, deassert after STAGES clk_in edges.
module jlsemi_util_async_reset_low_sync #(
  parameter int unsigned STAGES = 3
) (
  input  logic clk_in,
  input  logic rstn_in,
  output logic rstn_out
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      sync_q <= '0;
    end else begin
      sync_q <= (sync_q << 1) | STAGES'(1);
    end
  end

  assign rstn_out = sync_q[STAGES-1];

endmodule

// File: rtl/jlsemi_util_clkbuf.sv
// Clock buffer cell wrapper; behavioural pass-through, swapped for a library cell in implementation.
module jlsemi_util_clkbuf (
  input  logic clk_in_pre,
  output logic clk_out
);

  assign clk_out = clk_in_pre;

endmodule

// File: rtl/jlsemi_util_clkdiv_multi_phase_phase_ch.sv
// One divided-clock channel: modular phase compare against the shared counter, enable gate, output flop.
module jlsemi_util_clkdiv_phase_ch
  import jlsemi_util_clkdiv_multi_phase_pkg::*;
#(
  parameter int unsigned CNT_W = CLKDIV_CNT_W
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] cnt,
  input  logic [CNT_W-1:0] div_n,
  input  logic [CNT_W-1:0] ph,
  input  logic             en,
  output logic             clk_q
);

  logic [CNT_W:0] diff;
  logic [CNT_W:0] pos;
  logic [CNT_W:0] half;

  // (cnt - ph) mod N in CNT_W+1 bits; the top bit flags a negative difference.
  always_comb begin
    diff = {1'b0, cnt} - {1'b0, ph};
    pos  = diff[CNT_W] ? (diff + {1'b0, div_n}) : diff;
    half = {1'b0, div_n} >> 1;
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      clk_q <= 1'b0;
    end else begin
      clk_q <= en & (pos < half);
    end
  end

endmodule

// File: rtl/jlsemi_util_clkdiv_multi_phase.sv
// Programmable integer divider with NUM_CH phase-shifted outputs and period-aligned read strobe.
module jlsemi_util_clkdiv_multi_phase
  import jlsemi_util_clkdiv_multi_phase_pkg::*;
#(
  parameter int unsigned CNT_W          = CLKDIV_CNT_W,
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned DEF_DIV        = 4,
  parameter int unsigned RST_SYNC_STAGE = 3
) (
  input  logic                    clk_in,
  input  logic                    rstn_in,
  input  logic [CNT_W-1:0]        div_n,
  input  logic [NUM_CH*CNT_W-1:0] ch_phase,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic                    cfg_update,
  output logic [NUM_CH-1:0]       clk_out,
  output logic                    rd_en,
  output logic                    cfg_pending,
  output logic                    cfg_err
);

  logic                    rst_n;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        act_n;
  logic [CNT_W-1:0]        sh_n;
  logic [CNT_W-1:0]        nxt_n;
  logic [NUM_CH*CNT_W-1:0] act_ph;
  logic [NUM_CH*CNT_W-1:0] sh_ph;
  logic [NUM_CH*CNT_W-1:0] nxt_ph;
  logic [NUM_CH-1:0]       act_en;
  logic [NUM_CH-1:0]       sh_en;
  logic [NUM_CH-1:0]       nxt_en;
  logic [NUM_CH-1:0]       nxt_ok;
  logic [NUM_CH-1:0]       ch_q;
  logic                    pend_q;
  logic                    rd_q;
  logic                    wrap;
  logic                    do_apply;
  logic                    nxt_err;
  cfg_err_e                err_q;

  jlsemi_util_async_reset_low_sync #(
    .STAGES (RST_SYNC_STAGE)
  ) u_rst_sync (
    .clk_in   (clk_in),
    .rstn_in  (rstn_in),
    .rstn_out (rst_n)
  );

  assign wrap     = (cnt == (act_n - CNT_W'(1)));
  assign do_apply = wrap & (cfg_update | pend_q);

  // A strobe landing on the wrap cycle bypasses shadow and applies directly.
  always_comb begin
    nxt_n   = cfg_update ? div_n    : sh_n;
    nxt_ph  = cfg_update ? ch_phase : sh_ph;
    nxt_en  = cfg_update ? ch_en    : sh_en;
    nxt_ok  = '1;
    nxt_err = 1'b0;
    if (nxt_n < CNT_W'(DIV_MIN)) begin
      nxt_n   = CNT_W'(DIV_MIN);
      nxt_err = 1'b1;
    end
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (nxt_ph[k*CNT_W +: CNT_W] >= nxt_n) begin
        nxt_ok[k] = 1'b0;
        nxt_err   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (wrap) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sh_n   <= CNT_W'(DEF_DIV);
      sh_ph  <= '0;
      sh_en  <= '0;
      act_n  <= CNT_W'(DEF_DIV);
      act_ph <= '0;
      act_en <= '0;
      pend_q <= 1'b0;
    end else begin
      if (cfg_update) begin
        sh_n  <= div_n;
        sh_ph <= ch_phase;
        sh_en <= ch_en;
      end
      if (do_apply) begin
        act_n  <= nxt_n;
        act_ph <= nxt_ph;
        act_en <= nxt_en & nxt_ok;
        pend_q <= 1'b0;
      end else if (cfg_update) begin
        pend_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= 1'b0;
      err_q <= CFG_OK;
    end else begin
      rd_q <= wrap;
      if (do_apply && nxt_err) begin
        err_q <= CFG_ERR;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    jlsemi_util_clkdiv_phase_ch #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk_in (clk_in),
      .rst_n  (rst_n),
      .cnt    (cnt),
      .div_n  (act_n),
      .ph     (act_ph[g*CNT_W +: CNT_W]),
      .en     (act_en[g]),
      .clk_q  (ch_q[g])
    );

    jlsemi_util_clkbuf u_buf (
      .clk_in_pre (ch_q[g]),
      .clk_out    (clk_out[g])
    );
  end

  assign rd_en       = rd_q;
  assign cfg_pending = pend_q;
  assign cfg_err     = (err_q == CFG_ERR);

endmodule

// File: tb/tb_jlsemi_util_clkdiv_multi_phase.sv
// Scoreboard bench for the multi-phase divider: per-cycle expectations queued at drive time, popped after each edge.
module tb_jlsemi_util_clkdiv_multi_phase;

  localparam int unsigned CNT_W          = 9;
  localparam int unsigned NUM_CH         = 4;
  localparam int unsigned DEF_DIV        = 4;
  localparam int unsigned RST_SYNC_STAGE = 3;

  logic                    clk_in = 1'b0;
  logic                    rstn_in = 1'b0;
  logic [CNT_W-1:0]        div_n;
  logic [NUM_CH*CNT_W-1:0] ch_phase;
  logic [NUM_CH-1:0]       ch_en;
  logic                    cfg_update;
  logic [NUM_CH-1:0]       clk_out;
  logic                    rd_en;
  logic                    cfg_pending;
  logic                    cfg_err;

  jlsemi_util_clkdiv_multi_phase #(
    .CNT_W          (CNT_W),
    .NUM_CH         (NUM_CH),
    .DEF_DIV        (DEF_DIV),
    .RST_SYNC_STAGE (RST_SYNC_STAGE)
  ) dut (
    .clk_in      (clk_in),
    .rstn_in     (rstn_in),
    .div_n       (div_n),
    .ch_phase    (ch_phase),
    .ch_en       (ch_en),
    .cfg_update  (cfg_update),
    .clk_out     (clk_out),
    .rd_en       (rd_en),
    .cfg_pending (cfg_pending),
    .cfg_err     (cfg_err)
  );

  always #5 clk_in = ~clk_in;

  int n_tests;
  int n_fail;

  // Packed as {clk_out[3:0], rd_en, cfg_pending, cfg_err}.
  logic [6:0] sb[$];

  int m_cnt, m_n, s_n;
  int m_ph[NUM_CH];
  int s_ph[NUM_CH];
  bit m_en[NUM_CH];
  bit s_en[NUM_CH];
  bit m_pend, m_err;

  function automatic void model_reset();
    m_cnt = 0; m_n = DEF_DIV; s_n = DEF_DIV;
    m_pend = 1'b0; m_err = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      m_ph[k] = 0; m_en[k] = 1'b0; s_ph[k] = 0; s_en[k] = 1'b0;
    end
    sb.delete();
  endfunction

  // Predicts the outputs seen after the next edge from the current inputs, then advances one clock.
  task automatic step();
    logic [6:0]              e;
    logic [NUM_CH*CNT_W-1:0] phv;
    bit                      wrap;
    int                      src_n, nn;
    int                      src_ph[NUM_CH];
    bit                      src_en[NUM_CH];
    e    = '0;
    phv  = ch_phase;
    wrap = (m_cnt == m_n - 1);
    for (int k = 0; k < NUM_CH; k++)
      e[3+k] = m_en[k] && ((((m_cnt - m_ph[k]) % m_n + m_n) % m_n) < (m_n / 2));
    e[2] = wrap;
    src_n = cfg_update ? int'(div_n) : s_n;
    for (int k = 0; k < NUM_CH; k++) begin
      src_ph[k] = cfg_update ? int'(phv[k*CNT_W +: CNT_W]) : s_ph[k];
      src_en[k] = cfg_update ? ch_en[k] : s_en[k];
    end
    if (wrap && (cfg_update || m_pend)) begin
      nn = (src_n < 2) ? 2 : src_n;
      if (src_n < 2) m_err = 1'b1;
      for (int k = 0; k < NUM_CH; k++) begin
        m_ph[k] = src_ph[k];
        m_en[k] = src_en[k] && (src_ph[k] < nn);
        if (src_ph[k] >= nn) m_err = 1'b1;
      end
      m_n = nn;
      m_pend = 1'b0;
    end else if (cfg_update) begin
      m_pend = 1'b1;
    end
    if (cfg_update) begin
      s_n = src_n;
      for (int k = 0; k < NUM_CH; k++) begin
        s_ph[k] = src_ph[k]; s_en[k] = src_en[k];
      end
    end
    m_cnt = wrap ? 0 : m_cnt + 1;
    e[1] = m_pend;
    e[0] = m_err;
    sb.push_back(e);
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    rstn_in = 1'b0;
    cfg_update = 1'b0;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    rstn_in = 1'b1;
    repeat (RST_SYNC_STAGE) @(posedge clk_in);
    #1;
    model_reset();
  endtask

  task automatic test_reset();
    logic [6:0] got, exp;
    do_reset();
    n_tests++;
    got = {clk_out, rd_en, cfg_pending, cfg_err};
    if (got !== 7'b0) begin
      n_fail++; $display("FAIL reset_values got=%b exp=%b", got, 7'b0);
    end
    for (int i = 0; i < 8; i++) begin
      cfg_update = 1'b0;
      step();
      got = {clk_out, rd_en, cfg_pending, cfg_err}; exp = sb.pop_front(); n_tests++;
      if (got !== exp) begin
        n_fail++; $display("FAIL reset_idle cyc=%0d got=%b exp=%b", i, got, exp);
      end
    end
  endtask

  task automatic test_n4_stagger();
    logic [6:0]        got, exp;
    logic [NUM_CH-1:0] hist[24];
    int                last_rd, r;
    last_rd = -1;
    div_n = 9'd4; ch_phase = {9'd3, 9'd2, 9'd1, 9'd0}; ch_en = 4'hF;
    for (int i = 0; i < 24; i++) begin
      cfg_update = (i == 0);
      step();
      hist[i] = clk_out;
      got = {clk_out, rd_en, cfg_pending, cfg_err}; exp = sb.pop_front(); n_tests++;
      if (got !== exp) begin
        n_fail++; $display("FAIL n4_stagger cyc=%0d got=%b exp=%b", i, got, exp);
      end
      if (rd_en === 1'b1) begin
        if (last_rd >= 0) begin
          n_tests++;
          if (i - last_rd != 4) begin
            n_fail++; $display("FAIL n4_rd_period got=%0d exp=4", i - last_rd);
          end
        end
        last_rd = i;
      end
    end
    r = -1;
    for (int i = 8; i < 16; i++)
      if (r < 0 && hist[i][0] && !hist[i-1][0]) r = i;
    for (int k = 1; k < NUM_CH; k++) begin
      n_tests++;
      if (r < 0 || !(hist[r+k][k] && !hist[r+k-1][k])) begin
        n_fail++; $display("FAIL n4_rise_ch%0d got_rise0=%0d exp=rise at +%0d", k, r, k);
      end
    end
  endtask

  task automatic test_odd_n5();
    logic [6:0] got, exp;
    int         highs;
    highs = 0;
    div_n = 9'd5; ch_phase = '0; ch_en = 4'b0001;
    for (int i = 0; i < 30; i++) begin
      cfg_update = (i == 0);
      step();
      if (i >= 10 && clk_out[0] === 1'b1) highs++;
      got = {clk_out, rd_en, cfg_pending, cfg_err}; exp = sb.pop_front(); n_tests++;
      if (got !== exp) begin
        n_fail++; $display("FAIL odd_n5 cyc=%0d got=%b exp=%b", i, got, exp);
      end
    end
    n_tests++;
    if (highs != 8) begin
      n_fail++; $display("FAIL odd_n5_duty got=%0d high cycles exp=8", highs);
    end
  endtask

  task automatic test_mid_update();
    logic [6:0] got, exp;
    bit         done;
    int         ui;
    done = 1'b0; ui = -10;
    div_n = 9'd4; ch_phase = '0; ch_en = 4'b0001;
    for (int i = 0; i < 30; i++) begin
      cfg_update = 1'b0;
      if (i == 0) begin
        cfg_update = 1'b1;
      end else if (i >= 8 && !done && m_cnt == 1) begin
        div_n = 9'd6; cfg_update = 1'b1; done = 1'b1; ui = i;
      end
      step();
      got = {clk_out, rd_en, cfg_pending, cfg_err}; exp = sb.pop_front(); n_tests++;
      if (got !== exp) begin
        n_fail++; $display("FAIL mid_update cyc=%0d got=%b exp=%b", i, got, exp);
      end
      if (i == ui) begin
        n_tests++;
        if (cfg_pending !== 1'b1) begin
          n_fail++; $display("FAIL mid_pending got=%b exp=1", cfg_pending);
        end
      end
    end
  endtask

  task automatic test_wrap_update();
    logic [6:0] got, exp;
    bit         done, pend_seen;
    done = 1'b0; pend_seen = 1'b0;
    div_n = 9'd8; ch_phase = '0; ch_en = 4'b0001;
    for (int i = 0; i < 24; i++) begin
      cfg_update = 1'b0;
      if (i >= 2 && !done && m_cnt == m_n - 1) begin
        cfg_update = 1'b1; done = 1'b1;
      end
      step();
      if (cfg_pending !== 1'b0) pend_seen = 1'b1;
      got = {clk_out, rd_en, cfg_pending, cfg_err}; exp = sb.pop_front(); n_tests++;
      if (got !== exp) begin
        n_fail++; $display("FAIL wrap_update cyc=%0d got=%b exp=%b", i, got, exp);
      end
    end
    n_tests++;
    if (pend_seen || !done) begin
      n_fail++; $display("FAIL wrap_no_pending got=%b exp=0", pend_seen);
    end
  endtask

  task automatic test_illegal();
    logic [6:0] got, exp;
    div_n = 9'd1; ch_phase = {9'd3, 9'd0, 9'd0, 9'd0}; ch_en = 4'hF;
    for (int i = 0; i < 24; i++) begin
      cfg_update = (i == 0) || (i == 12);
      if (i == 12) begin
        div_n = 9'd4; ch_phase = '0;
      end
      step();
      got = {clk_out, rd_en, cfg_pending, cfg_err}; exp = sb.pop_front(); n_tests++;
      if (got !== exp) begin
        n_fail++; $display("FAIL illegal cyc=%0d got=%b exp=%b", i, got, exp);
      end
    end
    n_tests++;
    if (cfg_err !== 1'b1) begin
      n_fail++; $display("FAIL err_sticky got=%b exp=1", cfg_err);
    end
  endtask

  task automatic test_async_reset();
    logic [6:0] got, exp;
    div_n = 9'd6; ch_phase = '0; ch_en = 4'b0001;
    for (int i = 0; i < 30; i++) begin
      cfg_update = (i == 0);
      step();
      got = {clk_out, rd_en, cfg_pending, cfg_err}; exp = sb.pop_front(); n_tests++;
      if (got !== exp) begin
        n_fail++; $display("FAIL pre_reset cyc=%0d got=%b exp=%b", i, got, exp);
      end
      if (i >= 10 && clk_out[0] === 1'b1) break;
    end
    #2;
    rstn_in = 1'b0;
    #1;
    got = {clk_out, rd_en, cfg_pending, cfg_err}; n_tests++;
    if (got !== 7'b0) begin
      n_fail++; $display("FAIL async_reset got=%b exp=%b", got, 7'b0);
    end
    do_reset();
    for (int i = 0; i < 12; i++) begin
      cfg_update = 1'b0;
      step();
      got = {clk_out, rd_en, cfg_pending, cfg_err}; exp = sb.pop_front(); n_tests++;
      if (got !== exp) begin
        n_fail++; $display("FAIL post_reset cyc=%0d got=%b exp=%b", i, got, exp);
      end
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    div_n = 9'd4; ch_phase = '0; ch_en = '0; cfg_update = 1'b0;
    model_reset();
    test_reset();
    test_n4_stagger();
    test_odd_n5();
    test_mid_update();
    test_wrap_update();
    test_illegal();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/jlsemi_util_clkdiv_multi_phase.md
Name: jlsemi_util_clkdiv_multi_phase

Overview:
- Programmable integer clock divider producing NUM_CH phase-shifted divided clocks from one input clock.
- Supports both even and odd ratios.
- Ratio, phases and channel enables are updated without glitches at period boundaries through a shadow/active register pair.
- Serves as the capture-path clock generator for multi-lane ADC sampling. It provides per-lane sample clocks and a common period-aligned read strobe.

Parameters:
- CNT_W, 9: width of the divide ratio, the phase fields and the counter.
- NUM_CH, 4: number of divided clock output channels.
- DEF_DIV, 4: divide ratio loaded into the active config at reset. Must be >= 2.
- RST_SYNC_STAGE, 3: depth of the reset synchroniser.

Ports:
- clk_in  input  1  source clock; the only clock.
- rstn_in  input  1  asynchronous active-low reset; deassertion synchronised internally to clk_in.
- div_n  input  CNT_W  requested divide ratio N.
- ch_phase  input  NUM_CH*CNT_W  per-channel rising-edge offset in clk_in cycles; channel k occupies bits [k*CNT_W +: CNT_W].
- ch_en  input  NUM_CH  requested per-channel enable.
- cfg_update  input  1  single-cycle strobe; samples div_n, ch_phase and ch_en into shadow.
- clk_out  output  NUM_CH  divided clocks, registered, passed through a clock buffer.
- rd_en  output  1  one-cycle strobe per divided period.
- cfg_pending  output  1  shadow config waiting for a boundary.
- cfg_err  output  1  sticky error for an illegal applied config.

Behaviour:
- Reset is asynchronous assert and synchronous deassert after RST_SYNC_STAGE clk_in edges. Reset values:
  - cnt = 0
  - clk_out = 0
  - rd_en = 0
  - cfg_pending = 0
  - cfg_err = 0
  - active N = DEF_DIV, all phases = 0, all enables = 0
- Counter: cnt counts 0..N-1, then wraps to 0. The wrap cycle is the cycle where cnt == N-1.
- High time is H = floor(N/2).
  - Even N: exact 50% duty.
  - Odd N: high for H cycles, low for H+1 cycles. No negedge logic is used.
- Channel k output: in the cycle after cnt = c, clk_out[k] = en_k AND (((c - ph_k) mod N) < H).
  - The subtraction is done in CNT_W+1 bits, adding N when the result is negative.
  - Latency is one clk_in cycle.
  - The rising edge of clk_out[k] follows the cycle where cnt == ph_k.
- rd_en is 1 in the cycle after the wrap cycle and 0 otherwise. It is unaffected by ch_en.
- Config handshake:
  - cfg_update loads the shadow registers. It may be asserted in any cycle; the latest strobe wins.
  - cfg_pending rises the cycle after cfg_update. It falls in the cycle after shadow is copied to active.
  - The shadow-to-active copy happens only on a wrap cycle. The new config governs the cycle where cnt == 0.
  - If cfg_update coincides with a wrap cycle, the new values apply at that same wrap. In that case cfg_pending never asserts.
- Illegal config, checked on apply:
  - div_n < 2: active N is clamped to 2 and cfg_err is set.
  - ph_k >= N (after clamping): channel k is forced low for that config and cfg_err is set.
  - cfg_err clears only on reset.
- Enable changes take effect only at wrap. A disabled channel drives 0 from the next period. This avoids runt pulses.
- Reducing N below the current cnt cannot occur, because the change is applied only at wrap.
- Reset asserted mid-period forces all outputs low immediately (asynchronous).

Decomposition:
- Shared include file holds:
  - the CNT_W default
  - the minimum legal ratio constant DIV_MIN = 2
  - the cfg_err bit definition
- Reuse jlsemi_util_async_reset_low_sync for reset and jlsemi_util_clkbuf on each clk_out.
- Natural sub-module: jlsemi_util_clkdiv_phase_ch, one per channel. It contains the modular phase compare, the enable gating and the output flop.
- The top level holds the counter, the shadow/active registers, rd_en and cfg_err.

Test Plan:
- Reset, apply N=4, phases {0,1,2,3}, all enables -> each clk_out period is 4 cycles, 2 high. Rising edges are staggered by 1 cycle. rd_en pulses every 4 cycles.
- N=5, phase 0 -> clk_out[0] high 2 cycles, low 3 cycles, repeating. rd_en period is 5.
- Running N=4, cfg_update to N=6 at cnt=1 -> cfg_pending high until the wrap. The current 4-cycle period completes intact, then the next period is 6 cycles with no runt pulse.
- cfg_update to N=8 exactly on a wrap cycle -> the next period is 8 and cfg_pending stays 0.
- Apply div_n=1 with phase 3 -> N clamped to 2, channel forced low, cfg_err=1. It persists across later legal updates until reset.
- Reset asserted mid-high at N=6 -> all clk_out and rd_en go 0 asynchronously. After release, the config returns to DEF_DIV with all channels disabled.
